alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU, with a registered valid/ready handshake on both sides.
- Logic, add/sub and set-less-than complete in one cycle.
- Multiply (shift-add) and divide/remainder (restoring) run iteratively, one bit per cycle, so no large combinational multiplier or divider is needed.
- Sits between the register-file read stage and writeback; the control unit stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32: operand/result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request
- control  input  3  opcode
- sourceA  input  WIDTH  operand A / dividend / multiplicand
- sourceB  input  WIDTH  operand B / divisor / multiplier
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  primary result
- result_hi  output  WIDTH  MUL upper half; 0 for every other opcode
- zero  output  1  result == 0
- overflow  output  1  signed overflow on ADD/SUB; 0 otherwise
- div_by_zero  output  1  DIV/REM issued with sourceB == 0

Behaviour:
- Reset: clk is the only clock. rst_n low asynchronously forces the state to IDLE and clears every output register: result, result_hi, zero, overflow, div_by_zero, out_valid = 0. in_ready = 1 once rst_n is high. Reset mid-operation abandons the operation with no output.
- Opcodes:
  - 000 AND
  - 001 OR
  - 010 ADD (mod 2^WIDTH)
  - 011 DIV: unsigned quotient
  - 100 MUL: unsigned; lower WIDTH bits on result, upper WIDTH bits on result_hi
  - 101 REM: unsigned remainder
  - 110 SUB: A-B, mod 2^WIDTH
  - 111 SLT: signed A<B, giving result = {WIDTH-1 zeros, flag}
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
- Accept: in IDLE with in_valid=1, operands and opcode are captured at the clock edge.
  - Single-cycle opcodes (000,001,010,110,111) and DIV/REM with sourceB == 0 go IDLE->DONE. out_valid rises on the cycle after accept, so latency is 1.
  - MUL, DIV and REM with a nonzero divisor go IDLE->BUSY. The counter loads WIDTH and decrements once per BUSY cycle, one partial-product/quotient bit per cycle.
  - When the counter reaches 0, the FSM goes BUSY->DONE, so out_valid rises exactly WIDTH+1 cycles after the accept edge.
- DONE: result, result_hi and all flags are stable and held until out_ready=1 at a clock edge. The FSM then goes to IDLE, and in_ready is high the next cycle; there is no back-to-back accept in the same cycle.
  - out_ready held high while in DONE drains in one cycle.
  - out_ready asserted while not in DONE is ignored.
- Inputs: sourceA, sourceB and control are ignored outside the accept edge, so changing them during BUSY or DONE has no effect.
- Flags:
  - zero is computed over all WIDTH bits of result; result_hi is excluded.
  - overflow for ADD: operand signs equal and result sign differs.
  - overflow for SUB: operand signs differ and result sign differs from A.
- Divide by zero: div_by_zero=1, DIV gives result = all ones, REM gives result = sourceA, result_hi = 0.
- MUL never sets overflow. The full 2*WIDTH product is always exact.
- No X on outputs at any time after reset.

Test Plan:
- Reset mid-MUL:
  - Stimulus: issue MUL, A=7, B=9; pull rst_n low in cycle 10 of BUSY, then release.
  - Required response: out_valid, result and flags are 0 immediately, asynchronously; in_ready=1 after release; a new ADD 3+4 then returns 7 with latency 1.
- Single-cycle ops with out_ready=1:
  - Stimulus: ADD 0x7FFFFFFF+1, SUB 5-5, SLT -1<1, AND 0xF0F0&0x0FF0, OR 0xF000|0x000F.
  - Required response:
    - ADD: result 0x80000000, overflow=1
    - SUB: result 0, zero=1
    - SLT: result 1
    - AND: result 0x00F0
    - OR: result 0xF00F
    - each out_valid 1 cycle after accept
- MUL with backpressure:
  - Stimulus: MUL 0xFFFFFFFF*0xFFFFFFFF, out_ready held 0 for 5 cycles.
  - Required response: out_valid 33 cycles after accept; result=0x00000001, result_hi=0xFFFFFFFE held stable through backpressure; in_ready stays 0 until drained.
- DIV/REM:
  - Stimulus: DIV 100/7, REM 100/7, DIV 5/9.
  - Required response: 14, 2 and 0 (zero=1) respectively, each after 33 cycles; div_by_zero=0.
- Divide by zero:
  - Stimulus: DIV 42/0, REM 42/0.
  - Required response: result 0xFFFFFFFF and 42 respectively, div_by_zero=1, latency 1.
- Parametrised run at WIDTH=8:
  - Stimulus: MUL 200*3; DIV 255/16; operands changed during BUSY.
  - Required response:
    - MUL: result_hi=0x02, result=0x58
    - DIV: result 15
    - latency 9 cycles
    - operand changes during BUSY have no effect

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/add/sub/slt, iterative shift-add MUL and
// restoring DIV/REM, with registered valid/ready handshakes on both sides.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       control,
    input  logic [WIDTH-1:0] sourceA,
    input  logic [WIDTH-1:0] sourceB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_REM = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   in_ready_d;
    logic   out_valid_d;

    // Iteration datapath: hi_q/lo_q hold {partial product} for MUL and
    // {remainder, dividend/quotient} for DIV/REM; opnd_q is the multiplicand or divisor.
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;

    logic             accept;
    logic             start_iter;
    logic             last_step;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_dbz;
    logic             slt_flag;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] fin_res;
    logic [WIDTH-1:0] fin_hi;

    assign accept     = (state_q == S_IDLE) && in_valid;
    assign start_iter = (control == OP_MUL) ||
                        (((control == OP_DIV) || (control == OP_REM)) && (sourceB != '0));
    assign last_step  = (state_q == S_BUSY) && (cnt_q == CNT_W'(1));

    // State and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = start_iter ? S_BUSY : S_DONE;
            S_BUSY:  if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs follow the next state so they are available as flops
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        if (state_d == S_IDLE) in_ready_d = 1'b1;
        if (state_d == S_DONE) out_valid_d = 1'b1;
    end

    // Single-cycle operations, plus the divide-by-zero shortcut
    always_comb begin
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_dbz  = 1'b0;
        slt_flag = $signed(sourceA) < $signed(sourceB);
        case (control)
            OP_AND: alu_res = sourceA & sourceB;
            OP_OR:  alu_res = sourceA | sourceB;
            OP_ADD: begin
                alu_res = sourceA + sourceB;
                alu_ovf = (sourceA[WIDTH-1] == sourceB[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != sourceA[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sourceA - sourceB;
                alu_ovf = (sourceA[WIDTH-1] != sourceB[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != sourceA[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_flag};
            OP_DIV: begin
                alu_res = '1;
                alu_dbz = 1'b1;
            end
            OP_REM: begin
                alu_res = sourceA;
                alu_dbz = 1'b1;
            end
            default: alu_res = '0;
        endcase
    end

    // One MUL or DIV/REM bit per cycle, plus final result selection
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        if (op_q == OP_MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end
        fin_hi  = '0;
        fin_res = step_lo;
        if (op_q == OP_MUL) begin
            fin_hi = step_hi;
        end else if (op_q == OP_REM) begin
            fin_res = step_hi;
        end
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_AND;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            result      <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            op_q  <= control;
            cnt_q <= CNT_W'(WIDTH);
            hi_q  <= '0;
            if (control == OP_MUL) begin
                lo_q   <= sourceB;
                opnd_q <= sourceA;
            end else begin
                lo_q   <= sourceA;
                opnd_q <= sourceB;
            end
            if (!start_iter) begin
                result      <= alu_res;
                result_hi   <= '0;
                zero        <= (alu_res == '0);
                overflow    <= alu_ovf;
                div_by_zero <= alu_dbz;
            end
        end else if (state_q == S_BUSY) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_step) begin
                result      <= fin_res;
                result_hi   <= fin_hi;
                zero        <= (fin_res == '0);
                overflow    <= 1'b0;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table at WIDTH=32 and WIDTH=8, reset
// abandonment sequence, and randomized traffic against an arithmetic model.
module tb_alu_seq;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_REM = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic        clk;
    logic        rst_n;

    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [2:0]  control32;
    logic [31:0] sourceA32, sourceB32, result32, result_hi32;
    logic        zero32, overflow32, dbz32;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [2:0]  control8;
    logic [7:0]  sourceA8, sourceB8, result8, result_hi8;
    logic        zero8, overflow8, dbz8;

    int n_pass  = 0;
    int n_total = 0;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid32), .in_ready(in_ready32), .control(control32),
        .sourceA(sourceA32), .sourceB(sourceB32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .result(result32), .result_hi(result_hi32),
        .zero(zero32), .overflow(overflow32), .div_by_zero(dbz32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .control(control8),
        .sourceA(sourceA8), .sourceB(sourceB8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .result_hi(result_hi8),
        .zero(zero8), .overflow(overflow8), .div_by_zero(dbz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [63:0] hi;
        logic        z;
        logic        ovf;
        logic        dbz;
        logic        irdy;
        logic        ovld;
    } obs_t;

    typedef struct {
        logic [63:0] res;
        logic [63:0] hi;
        logic        z;
        logic        ovf;
        logic        dbz;
        int          lat;
    } exp_t;

    typedef struct {
        bit          s8;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        int          stall;
        exp_t        e;
    } vec_t;

    function automatic exp_t mk_exp(logic [63:0] res, logic [63:0] hi, logic z,
                                    logic ovf, logic dbz, int lat);
        exp_t e;
        e.res = res; e.hi = hi; e.z = z; e.ovf = ovf; e.dbz = dbz; e.lat = lat;
        return e;
    endfunction

    function automatic vec_t mkv(bit s8, logic [2:0] op, logic [63:0] a, logic [63:0] b,
                                 int stall, exp_t e);
        vec_t v;
        v.s8 = s8; v.op = op; v.a = a; v.b = b; v.stall = stall; v.e = e;
        return v;
    endfunction

    // Reference model: plain integer arithmetic on w-bit values
    function automatic exp_t model(int w, logic [2:0] op, logic [63:0] a_in, logic [63:0] b_in);
        exp_t e;
        longint unsigned m, a, b, prod;
        longint half, sa, sb, s;
        m    = (64'd1 << w) - 64'd1;
        a    = a_in & m;
        b    = b_in & m;
        half = longint'(64'd1 << (w - 1));
        sa   = (longint'(a) >= half) ? longint'(a) - 2 * half : longint'(a);
        sb   = (longint'(b) >= half) ? longint'(b) - 2 * half : longint'(b);
        e.res = 0; e.hi = 0; e.ovf = 0; e.dbz = 0; e.lat = 1;
        case (op)
            OP_AND: e.res = a & b;
            OP_OR:  e.res = a | b;
            OP_ADD: begin
                s = sa + sb;
                e.res = (a + b) & m;
                e.ovf = (s >= half) || (s < -half);
            end
            OP_SUB: begin
                s = sa - sb;
                e.res = (a - b) & m;
                e.ovf = (s >= half) || (s < -half);
            end
            OP_SLT: e.res = (sa < sb) ? 64'd1 : 64'd0;
            OP_MUL: begin
                prod  = a * b;
                e.res = prod & m;
                e.hi  = (prod >> w) & m;
                e.lat = w + 1;
            end
            OP_DIV: begin
                if (b == 0) begin e.res = m; e.dbz = 1; end
                else begin e.res = a / b; e.lat = w + 1; end
            end
            default: begin
                if (b == 0) begin e.res = a; e.dbz = 1; end
                else begin e.res = a % b; e.lat = w + 1; end
            end
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    function automatic obs_t snap(bit s8);
        obs_t o;
        if (s8) begin
            o.res = {56'd0, result8}; o.hi = {56'd0, result_hi8};
            o.z = zero8; o.ovf = overflow8; o.dbz = dbz8;
            o.irdy = in_ready8; o.ovld = out_valid8;
        end else begin
            o.res = {32'd0, result32}; o.hi = {32'd0, result_hi32};
            o.z = zero32; o.ovf = overflow32; o.dbz = dbz32;
            o.irdy = in_ready32; o.ovld = out_valid32;
        end
        return o;
    endfunction

    task automatic drive(bit s8, logic [2:0] op, logic [63:0] a, logic [63:0] b,
                         logic v, logic r);
        if (s8) begin
            control8 = op; sourceA8 = a[7:0]; sourceB8 = b[7:0];
            in_valid8 = v; out_ready8 = r;
        end else begin
            control32 = op; sourceA32 = a[31:0]; sourceB32 = b[31:0];
            in_valid32 = v; out_ready32 = r;
        end
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One transaction; operands are scrambled after accept, results checked for
    // stability through stall cycles, and drain is checked at the end.
    task automatic txn(bit s8, logic [2:0] op, logic [63:0] a, logic [63:0] b, int stall,
                       output obs_t got, output int lat, output bit hs_ok);
        obs_t o;
        int   guard;
        logic rdy;
        hs_ok = 1'b1;
        guard = 0;
        rdy   = (stall == 0);
        @(negedge clk);
        o = snap(s8);
        while (!o.irdy && guard < 100) begin
            @(negedge clk);
            o = snap(s8);
            guard++;
        end
        if (!o.irdy) hs_ok = 1'b0;
        drive(s8, op, a, b, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        lat = 1;
        drive(s8, 3'($urandom), 64'($urandom), 64'($urandom), 1'b0, rdy);
        o = snap(s8);
        while (!o.ovld && lat < 200) begin
            if (o.irdy) hs_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
            drive(s8, 3'($urandom), 64'($urandom), 64'($urandom), 1'b0, rdy);
            o = snap(s8);
        end
        got = o;
        if (o.irdy) hs_ok = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            o = snap(s8);
            if (!o.ovld || o.irdy || o.res !== got.res || o.hi !== got.hi ||
                o.z !== got.z || o.ovf !== got.ovf || o.dbz !== got.dbz) hs_ok = 1'b0;
        end
        drive(s8, 3'($urandom), 64'($urandom), 64'($urandom), 1'b0, 1'b1);
        @(posedge clk);
        #1;
        o = snap(s8);
        if (o.ovld || !o.irdy) hs_ok = 1'b0;
        drive(s8, 3'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic run_check(string tag, bit s8, logic [2:0] op, logic [63:0] a,
                             logic [63:0] b, int stall, exp_t e);
        obs_t got;
        int   lat;
        bit   hs_ok;
        txn(s8, op, a, b, stall, got, lat, hs_ok);
        chk({tag, ".result"},    got.res, e.res);
        chk({tag, ".result_hi"}, got.hi, e.hi);
        chk({tag, ".zero"},      64'(got.z), 64'(e.z));
        chk({tag, ".overflow"},  64'(got.ovf), 64'(e.ovf));
        chk({tag, ".div_by_0"},  64'(got.dbz), 64'(e.dbz));
        chk({tag, ".latency"},   64'(lat), 64'(e.lat));
        chk({tag, ".handshake"}, 64'(hs_ok), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vt[$];
        obs_t o;
        bit   seen;

        rst_n = 1'b0;
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        drive(1'b1, 3'd0, 64'd0, 64'd0, 1'b0, 1'b0);

        // Reset state
        #12;
        o = snap(1'b0);
        chk("rst.out_valid", 64'(o.ovld), 64'd0);
        chk("rst.result", o.res, 64'd0);
        chk("rst.flags", {61'd0, o.z, o.ovf, o.dbz}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.in_ready32", 64'(in_ready32), 64'd1);
        chk("rst.in_ready8", 64'(in_ready8), 64'd1);

        // Directed vectors with hand-derived expectations
        vt.push_back(mkv(0, OP_ADD, 64'h7FFF_FFFF, 64'h1, 0, mk_exp(64'h8000_0000, 0, 0, 1, 0, 1)));
        vt.push_back(mkv(0, OP_SUB, 64'd5, 64'd5, 0, mk_exp(64'd0, 0, 1, 0, 0, 1)));
        vt.push_back(mkv(0, OP_SLT, 64'hFFFF_FFFF, 64'd1, 0, mk_exp(64'd1, 0, 0, 0, 0, 1)));
        vt.push_back(mkv(0, OP_AND, 64'hF0F0, 64'h0FF0, 0, mk_exp(64'h00F0, 0, 0, 0, 0, 1)));
        vt.push_back(mkv(0, OP_OR, 64'hF000, 64'h000F, 0, mk_exp(64'hF00F, 0, 0, 0, 0, 1)));
        vt.push_back(mkv(0, OP_SUB, 64'h8000_0000, 64'd1, 2, mk_exp(64'h7FFF_FFFF, 0, 0, 1, 0, 1)));
        vt.push_back(mkv(0, OP_MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5,
                         mk_exp(64'h1, 64'hFFFF_FFFE, 0, 0, 0, 33)));
        vt.push_back(mkv(0, OP_DIV, 64'd100, 64'd7, 0, mk_exp(64'd14, 0, 0, 0, 0, 33)));
        vt.push_back(mkv(0, OP_REM, 64'd100, 64'd7, 1, mk_exp(64'd2, 0, 0, 0, 0, 33)));
        vt.push_back(mkv(0, OP_DIV, 64'd5, 64'd9, 0, mk_exp(64'd0, 0, 1, 0, 0, 33)));
        vt.push_back(mkv(1, OP_MUL, 64'd200, 64'd3, 2, mk_exp(64'h58, 64'h02, 0, 0, 0, 9)));
        vt.push_back(mkv(1, OP_DIV, 64'd255, 64'd16, 0, mk_exp(64'd15, 0, 0, 0, 0, 9)));
        vt.push_back(mkv(0, OP_DIV, 64'd42, 64'd0, 0, mk_exp(64'hFFFF_FFFF, 0, 0, 0, 1, 1)));
        vt.push_back(mkv(0, OP_REM, 64'd42, 64'd0, 3, mk_exp(64'd42, 0, 0, 0, 1, 1)));

        foreach (vt[i])
            run_check($sformatf("vec%0d", i), vt[i].s8, vt[i].op, vt[i].a, vt[i].b,
                      vt[i].stall, vt[i].e);

        // Reset in the middle of a MUL: outputs clear at once, nothing emerges
        @(negedge clk);
        drive(1'b0, OP_MUL, 64'd7, 64'd9, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        o = snap(1'b0);
        chk("midrst.out_valid", 64'(o.ovld), 64'd0);
        chk("midrst.result", o.res, 64'd0);
        chk("midrst.result_hi", o.hi, 64'd0);
        chk("midrst.flags", {61'd0, o.z, o.ovf, o.dbz}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 3'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid32 || !in_ready32) seen = 1'b1;
        end
        chk("midrst.no_output", 64'(seen), 64'd0);
        run_check("midrst.add", 1'b0, OP_ADD, 64'd3, 64'd4, 0, mk_exp(64'd7, 0, 0, 0, 0, 1));

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            bit          s8;
            logic [2:0]  op;
            logic [63:0] a, b;
            int          sel;
            s8  = (i % 4 == 3);
            op  = 3'($urandom_range(0, 7));
            a   = 64'($urandom);
            sel = $urandom_range(0, 7);
            if (sel == 0)      b = 64'd0;
            else if (sel < 3)  b = 64'($urandom_range(1, 20));
            else               b = 64'($urandom);
            if (s8) begin
                a = a & 64'hFF;
                b = b & 64'hFF;
            end
            run_check($sformatf("rnd%0d", i), s8, op, a, b, $urandom_range(0, 3),
                      model(s8 ? 8 : 32, op, a, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
